spindash_bus: RTL
=================

SPINDASH_BUS -- requirements
Module: spindash_bus

Interface
REQ-001 SHALL have parameter CEN_DIV, default 6: clk50 cycles per cen pulse, legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: write-queue entries, power of two, 2..256.
REQ-003 SHALL have parameter ADDR_WAIT, default 2: cen periods idle after an address write.
REQ-004 SHALL have parameter DATA_WAIT, default 32: cen periods idle after a data write.
REQ-005 SHALL have ports:
- clk50  in  1  sole clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  host write request
- wr_ready  out  1  queue can accept
- wr_bank  in  1  0 = channels 1-3, 1 = channels 4-6
- wr_reg  in  8  register address
- wr_data  in  8  register value
- flush  in  1  discard queued entries
- cen  out  1  one-clk50 clock-enable pulse to the FM core
- ym_din  out  8  FM bus data
- ym_addr  out  2  FM bus addr; bit0 reg/data, bit1 bank
- ym_cs_n  out  1  FM chip select, active low
- ym_wr_n  out  1  FM write strobe, active low
- ym_dout  in  8  FM status read-back
- level  out  clog2(FIFO_DEPTH)+1  queued entry count
- busy  out  1  sequencer not IDLE or queue non-empty
- overflow  out  1  sticky: write attempted while full

Function
REQ-006 cen SHALL pulse high one clk50 cycle in every CEN_DIV, counter 0..CEN_DIV-1 wrapping, pulse at count 0.
REQ-007 Entry {bank,reg,data} SHALL enqueue on clk50 edge with wr_valid && wr_ready; wr_ready = (level < FIFO_DEPTH).
REQ-008 wr_valid while full SHALL drop the entry and set overflow; overflow clears only on reset or flush.
REQ-009 Simultaneous enqueue and dequeue SHALL leave level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-010 FSM states: IDLE, ADDR, AWAIT, DATA, DWAIT; all transitions occur only on cen-high cycles.
REQ-011 IDLE -> ADDR on cen when queue non-empty; head entry popped into holding register at that edge.
REQ-012 ADDR: ym_addr={bank,0}, ym_din=reg, ym_cs_n=ym_wr_n=0 for exactly one cen period (CEN_DIV clk50 cycles); then AWAIT.
REQ-013 AWAIT: strobes high for ADDR_WAIT cen periods (0 = skip); then DATA.
REQ-014 DATA: ym_addr={bank,1}, ym_din=data, strobes low one cen period; then DWAIT.
REQ-015 DWAIT: strobes high DATA_WAIT cen periods; then ADDR if queue non-empty (back-to-back, no IDLE visit) else IDLE.
REQ-016 ym_cs_n and ym_wr_n SHALL be registered, glitch-free, and identical at all times.
REQ-017 flush SHALL zero level and pointers the next edge; an entry already in the holding register SHALL complete; wr_valid coincident with flush is dropped.
REQ-018 busy SHALL be 0 only when state=IDLE and level=0.

Reset
REQ-019 rst_n low SHALL asynchronously force: cen=0, divider count=0, state=IDLE, level=0, pointers=0, overflow=0, busy=0, ym_cs_n=1, ym_wr_n=1, ym_addr=0, ym_din=0, wr_ready=0.
REQ-020 wr_ready SHALL rise one clk50 cycle after rst_n deassertion; divider restarts so first cen occurs CEN_DIV clk50 cycles after release.
REQ-021 Reset mid-strobe SHALL deassert ym_wr_n immediately and discard the in-flight entry.

Configuration
REQ-022 With SPINDASH_BUSY_POLL_EN defined, DWAIT SHALL instead hold until ym_dout[7]=0 sampled on a cen cycle, minimum one cen period, DATA_WAIT unused; ym_cs_n low, ym_wr_n high, ym_addr=0 during polling.
REQ-023 Without SPINDASH_BUSY_POLL_EN, ym_dout SHALL be ignored and DWAIT uses DATA_WAIT.

Verification
REQ-024 Reset release, CEN_DIV=6: cen high at clk50 cycles 6,12,18...; no strobes; busy=0.
REQ-025 One write bank=1 reg=0x28 data=0xF1: ym_addr=2/din=0x28 strobe 6 clk, 2 cen idle, ym_addr=3/din=0xF1 strobe 6 clk, 32 cen idle, IDLE.
REQ-026 FIFO_DEPTH=4, 6 writes back-to-back: first 4 (or 5 if one popped) accepted, overflow=1, writes emitted in order with no IDLE gap.
REQ-027 flush after 3 queued, one in flight: in-flight pair completes, remaining 3 never appear, level=0.
REQ-028 rst_n low during DATA strobe: ym_wr_n=1 same cycle, after release no pending write emitted.
REQ-029 SPINDASH_BUSY_POLL_EN, ym_dout[7] held 1 for 10 cen: next ADDR strobe starts on first cen after ym_dout[7]=0.

Source files
------------

// File: rtl/spindash_bus.sv
// rtl/spindash_bus.sv - FM bus write sequencer with host write queue; optional SPINDASH_BUSY_POLL_EN busy polling
module spindash_bus #(
   parameter int CEN_DIV    = 6,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_WAIT  = 2,
   parameter int DATA_WAIT  = 32
) (
   input  logic                          clk50,
   input  logic                          rst_n,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic                          wr_bank,
   input  logic [7:0]                    wr_reg,
   input  logic [7:0]                    wr_data,
   input  logic                          flush,
   output logic                          cen,
   output logic [7:0]                    ym_din,
   output logic [1:0]                    ym_addr,
   output logic                          ym_cs_n,
   output logic                          ym_wr_n,
   input  logic [7:0]                    ym_dout,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          busy,
   output logic                          overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int DW = $clog2(CEN_DIV);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_AWAIT = 3'd2,
      S_DATA  = 3'd3,
      S_DWAIT = 3'd4
   } state_t;

   // queue entry layout: {bank, reg, data}
   logic [16:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [DW-1:0] div_cnt;
   logic          rdy_en;
   logic          push;
   logic          pop;
   logic          q_avail;
   logic          dw_exit;

   state_t        state;
   state_t        state_d;
   logic [7:0]    wcnt;
   logic [7:0]    wcnt_d;
   logic [16:0]   hold;
   logic [16:0]   hold_d;

   logic          cs_n_d;
   logic          wr_n_d;
   logic [1:0]    addr_d;
   logic [7:0]    din_d;

   logic          unused_dout;

`ifdef SPINDASH_BUSY_POLL_EN
   assign unused_dout = ^ym_dout[6:0];
`else
   assign unused_dout = ^ym_dout;
`endif

   // flush wins over both ends of the queue: nothing enters and nothing is popped on that edge
   assign wr_ready = rdy_en && (level < LW'(FIFO_DEPTH));
   assign push     = wr_valid && wr_ready && !flush;
   assign q_avail  = (level != '0) && !flush;
   assign busy     = (state != S_IDLE) || (level != '0);

   // clock-enable divider; restarts from zero so the first pulse lands CEN_DIV cycles after reset release
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         cen     <= 1'b0;
      end else if (div_cnt == DW'(CEN_DIV - 1)) begin
         div_cnt <= '0;
         cen     <= 1'b1;
      end else begin
         div_cnt <= div_cnt + DW'(1);
         cen     <= 1'b0;
      end
   end

   // host side becomes ready one cycle after reset release
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) rdy_en <= 1'b0;
      else        rdy_en <= 1'b1;
   end

   // queue storage, no reset needed since level gates every read
   always_ff @(posedge clk50) begin
      if (push) mem[wptr] <= {wr_bank, wr_reg, wr_data};
   end

   // queue pointers and occupancy
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // sticky overflow: a write offered while the queue is full, cleared only by flush
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n)                                 overflow <= 1'b0;
      else if (flush)                             overflow <= 1'b0;
      else if (wr_valid && rdy_en && !wr_ready)   overflow <= 1'b1;
   end

   // sequencer state, holding register and registered bus outputs
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         wcnt    <= '0;
         hold    <= '0;
         ym_cs_n <= 1'b1;
         ym_wr_n <= 1'b1;
         ym_addr <= 2'b00;
         ym_din  <= 8'h00;
      end else begin
         state   <= state_d;
         wcnt    <= wcnt_d;
         hold    <= hold_d;
         ym_cs_n <= cs_n_d;
         ym_wr_n <= wr_n_d;
         ym_addr <= addr_d;
         ym_din  <= din_d;
      end
   end

   // next-state: every move happens on a cen cycle; a pop refills the holding register
   always_comb begin
      state_d = state;
      wcnt_d  = wcnt;
      pop     = 1'b0;
      dw_exit = 1'b0;
      case (state)
         S_IDLE: begin
            if (cen && q_avail) begin
               state_d = S_ADDR;
               pop     = 1'b1;
            end
         end
         S_ADDR: begin
            if (cen) begin
               if (ADDR_WAIT == 0) begin
                  state_d = S_DATA;
               end else begin
                  state_d = S_AWAIT;
                  wcnt_d  = 8'(ADDR_WAIT - 1);
               end
            end
         end
         S_AWAIT: begin
            if (cen) begin
               if (wcnt == '0) state_d = S_DATA;
               else            wcnt_d  = wcnt - 8'd1;
            end
         end
         S_DATA: begin
            if (cen) begin
`ifdef SPINDASH_BUSY_POLL_EN
               state_d = S_DWAIT;
`else
               if (DATA_WAIT == 0) begin
                  dw_exit = 1'b1;
               end else begin
                  state_d = S_DWAIT;
                  wcnt_d  = 8'(DATA_WAIT - 1);
               end
`endif
            end
         end
         S_DWAIT: begin
            if (cen) begin
`ifdef SPINDASH_BUSY_POLL_EN
               if (!ym_dout[7]) dw_exit = 1'b1;
`else
               if (wcnt == '0) dw_exit = 1'b1;
               else            wcnt_d  = wcnt - 8'd1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
      // leaving the data wait goes straight to the next address phase when work is queued
      if (dw_exit) begin
         if (q_avail) begin
            state_d = S_ADDR;
            pop     = 1'b1;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   // next bus outputs from the next state so strobes switch exactly with the state register
   always_comb begin
      hold_d = pop ? mem[rptr] : hold;
      cs_n_d = 1'b1;
      wr_n_d = 1'b1;
      addr_d = 2'b00;
      din_d  = 8'h00;
      case (state_d)
         S_ADDR: begin
            cs_n_d = 1'b0;
            wr_n_d = 1'b0;
            addr_d = {hold_d[16], 1'b0};
            din_d  = hold_d[15:8];
         end
         S_DATA: begin
            cs_n_d = 1'b0;
            wr_n_d = 1'b0;
            addr_d = {hold_d[16], 1'b1};
            din_d  = hold_d[7:0];
         end
`ifdef SPINDASH_BUSY_POLL_EN
         S_DWAIT: begin
            cs_n_d = 1'b0;
         end
`endif
         default: begin
            cs_n_d = 1'b1;
            wr_n_d = 1'b1;
         end
      endcase
   end

endmodule
